// File: rtl/axi3_master_bridge.sv
// Converts single-word req/ack requests into single-beat AXI3 master read/write transactions.
// A timeout reports an error to the requester, and the AXI side is then drained cleanly.
module axi3_master_bridge #(
  parameter int unsigned TIMEOUT = 1048575,
  parameter logic [11:0] ID      = 12'h000,
  parameter logic [2:0]  PROT    = 3'b000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inreq,
  input  logic        inwr,
  input  logic [31:0] inaddr,
  input  logic [31:0] inwdata,
  input  logic [3:0]  inwstrb,
  output logic        inack,
  output logic        inerr,
  output logic [31:0] inrdata,
  output logic        axiarvalid,
  input  logic        axiarready,
  output logic [31:0] axiaraddr,
  output logic [11:0] axiarid,
  output logic [3:0]  axiarlen,
  output logic [2:0]  axiarsize,
  output logic [1:0]  axiarburst,
  output logic [1:0]  axiarlock,
  output logic [3:0]  axiarcache,
  output logic [3:0]  axiarqos,
  output logic [2:0]  axiarprot,
  input  logic        axirvalid,
  output logic        axirready,
  input  logic [31:0] axirdata,
  input  logic [1:0]  axirresp,
  input  logic        axirlast,
  input  logic [11:0] axirid,
  output logic        axiawvalid,
  input  logic        axiawready,
  output logic [31:0] axiawaddr,
  output logic [11:0] axiawid,
  output logic [3:0]  axiawlen,
  output logic [2:0]  axiawsize,
  output logic [1:0]  axiawburst,
  output logic [1:0]  axiawlock,
  output logic [3:0]  axiawcache,
  output logic [3:0]  axiawqos,
  output logic [2:0]  axiawprot,
  output logic        axiwvalid,
  input  logic        axiwready,
  output logic [31:0] axiwdata,
  output logic [3:0]  axiwstrb,
  output logic        axiwlast,
  output logic [11:0] axiwid,
  input  logic        axibvalid,
  output logic        axibready,
  input  logic [1:0]  axibresp,
  input  logic [11:0] axibid
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RDADDR = 3'd1;
  localparam logic [2:0] S_RDDATA = 3'd2;
  localparam logic [2:0] S_WRXFER = 3'd3;
  localparam logic [2:0] S_WRRESP = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          is_wr_q, is_wr_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          inack_q, inack_d, inerr_q, inerr_d;
  logic          aw_left, w_left, active;

  // Fields not needed for single-beat, single-outstanding operation.
  logic unused_ok;
  assign unused_ok = ^{axirlast, axirid, axibid, axirresp[0], axibresp[0]};

  assign aw_left = awvalid_q & ~axiawready;
  assign w_left  = wvalid_q & ~axiwready;
  assign active  = (state_q == S_RDADDR) || (state_q == S_RDDATA) ||
                   (state_q == S_WRXFER) || (state_q == S_WRRESP);

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    is_wr_d   = is_wr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    inack_d   = 1'b0;
    inerr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inreq) begin
          addr_d  = inaddr;
          is_wr_d = inwr;
          timer_d = TW'(TIMEOUT);
          if (inwr) begin
            wdata_d   = inwdata;
            wstrb_d   = inwstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRXFER;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RDADDR;
          end
        end
      end
      S_RDADDR: begin
        if (axiarready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDDATA;
        end
      end
      S_RDDATA: begin
        if (axirvalid) begin
          rready_d = 1'b0;
          rdata_d  = axirdata;
          inack_d  = 1'b1;
          inerr_d  = axirresp[1];
          state_d  = S_IDLE;
        end
      end
      S_WRXFER: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = S_WRRESP;
        end
      end
      S_WRRESP: begin
        if (axibvalid) begin
          bready_d = 1'b0;
          inack_d  = 1'b1;
          inerr_d  = axibresp[1];
          state_d  = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Finish whatever handshakes are open, swallow the response, stay silent.
        if (is_wr_q) begin
          awvalid_d = aw_left;
          wvalid_d  = w_left;
          if ((awvalid_q || wvalid_q) && !aw_left && !w_left) begin
            bready_d = 1'b1;
          end else if (bready_q && axibvalid) begin
            bready_d = 1'b0;
            state_d  = S_IDLE;
          end
        end else if (arvalid_q) begin
          if (axiarready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
        end else if (rready_q && axirvalid) begin
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Expiry lands on the edge where the timer reaches zero; a same-cycle completion wins.
    if (active) begin
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      if (timer_q <= TW'(1) && state_d != S_IDLE) begin
        inack_d = 1'b1;
        inerr_d = 1'b1;
        rdata_d = '0;
        state_d = S_DRAIN;
      end
    end
  end

  // NOTE: all state is reset, including the datapath registers, because inrdata is visible at reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      is_wr_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      inack_q   <= 1'b0;
      inerr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      is_wr_q   <= is_wr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      inack_q   <= inack_d;
      inerr_q   <= inerr_d;
    end
  end

  assign inack      = inack_q;
  assign inerr      = inerr_q;
  assign inrdata    = rdata_q;

  assign axiarvalid = arvalid_q;
  assign axiaraddr  = addr_q;
  assign axiarid    = ID;
  assign axiarlen   = 4'd0;
  assign axiarsize  = 3'd2;
  assign axiarburst = 2'b01;
  assign axiarlock  = 2'b00;
  assign axiarcache = 4'd0;
  assign axiarqos   = 4'd0;
  assign axiarprot  = PROT;
  assign axirready  = rready_q;

  assign axiawvalid = awvalid_q;
  assign axiawaddr  = addr_q;
  assign axiawid    = ID;
  assign axiawlen   = 4'd0;
  assign axiawsize  = 3'd2;
  assign axiawburst = 2'b01;
  assign axiawlock  = 2'b00;
  assign axiawcache = 4'd0;
  assign axiawqos   = 4'd0;
  assign axiawprot  = PROT;

  assign axiwvalid  = wvalid_q;
  assign axiwdata   = wdata_q;
  assign axiwstrb   = wstrb_q;
  assign axiwlast   = 1'b1;
  assign axiwid     = ID;
  assign axibready  = bready_q;

endmodule
